// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-limited sharing of one UART transmit engine.
// Define TXARB_PRIORITY_EN to make requester 0 strict high priority.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    parameter int IDW       = 3
) (
    input  logic              clk100mhz,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    input  logic              tx_rdy,
    output logic              tx_load,
    output logic [7:0]        tx_data,
    output logic [IDW-1:0]    gnt_id,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    localparam logic [3:0] BMAX = 4'(MAX_BURST - 1);
`ifdef TXARB_PRIORITY_EN
    localparam logic [IDW-1:0] FIRST = IDW'(1);
`else
    localparam logic [IDW-1:0] FIRST = '0;
`endif

    state_t         state, state_nx;
    logic [IDW-1:0] rr_ptr;
    logic [3:0]     burst_cnt;
    logic [IDW-1:0] pick_id, wrap_nx;
    logic           pick_vld, cur_req;
    logic [7:0]     pick_data, cur_data;
    logic           do_grant, do_cont, do_pre, do_rot;

    // Winner is the requester closest to rr_ptr going upward.
    always_comb begin
        int best;
        int d;
        best     = NREQ;
        pick_id  = '0;
        for (int i = 0; i < NREQ; i++) begin
            d = i - int'(rr_ptr);
            if (d < 0)
                d = d + NREQ;
`ifdef TXARB_PRIORITY_EN
            if (req[i] && i != 0 && d < best) begin
`else
            if (req[i] && d < best) begin
`endif
                best    = d;
                pick_id = IDW'(i);
            end
        end
        pick_vld = (best < NREQ);
`ifdef TXARB_PRIORITY_EN
        if (req[0]) begin
            pick_vld = 1'b1;
            pick_id  = '0;
        end
`endif
    end

    always_comb begin
        cur_req   = 1'b0;
        cur_data  = 8'h00;
        pick_data = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                cur_req  = req[i];
                cur_data = req_data[8*i +: 8];
            end
            if (pick_id == IDW'(i))
                pick_data = req_data[8*i +: 8];
        end
        if (int'(gnt_id) + 1 >= NREQ)
            wrap_nx = FIRST;
        else
            wrap_nx = gnt_id + 1'b1;
    end

    always_ff @(posedge clk100mhz or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        do_grant = 1'b0;
        do_cont  = 1'b0;
        do_pre   = 1'b0;
        do_rot   = 1'b0;
        unique case (state)
            IDLE:
                if (tx_rdy && pick_vld) begin
                    state_nx = LOAD;
                    do_grant = 1'b1;
                end
            LOAD:
                state_nx = WAIT_BUSY;
            WAIT_BUSY:
                if (!tx_rdy)
                    state_nx = WAIT_DONE;
            WAIT_DONE:
                if (tx_rdy) begin
`ifdef TXARB_PRIORITY_EN
                    if (req[0] && gnt_id != '0) begin
                        state_nx = LOAD;
                        do_pre   = 1'b1;
                        do_rot   = 1'b1;
                    end else
`endif
                    if (cur_req && burst_cnt < BMAX) begin
                        state_nx = LOAD;
                        do_cont  = 1'b1;
                    end else begin
                        state_nx = IDLE;
`ifdef TXARB_PRIORITY_EN
                        do_rot   = (gnt_id != '0);
`else
                        do_rot   = 1'b1;
`endif
                    end
                end
            default:
                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk100mhz or negedge reset) begin
        if (!reset) begin
            gnt_id    <= '0;
            tx_data   <= 8'h00;
            burst_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            if (do_grant) begin
                gnt_id    <= pick_id;
                tx_data   <= pick_data;
                burst_cnt <= '0;
            end else if (do_pre) begin
                gnt_id    <= '0;
                tx_data   <= req_data[7:0];
                burst_cnt <= '0;
            end else if (do_cont) begin
                tx_data   <= cur_data;
                burst_cnt <= burst_cnt + 1'b1;
            end
            if (do_rot)
                rr_ptr <= wrap_nx;
        end
    end

    always_comb begin
        tx_load = (state == LOAD);
        busy    = (state != IDLE);
        ack     = '0;
        for (int i = 0; i < NREQ; i++)
            if (state == LOAD && gnt_id == IDW'(i))
                ack[i] = 1'b1;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a queue-level
// arbitration model and a simple TXRDY engine model.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int MB   = 4;
    localparam int IDW  = 3;

    typedef struct {
        int         id;
        logic [7:0] d;
    } exp_t;

    logic              clk100mhz;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic              tx_rdy;
    logic              tx_load;
    logic [7:0]        tx_data;
    logic [IDW-1:0]    gnt_id;
    logic              busy;

    uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MB), .IDW(IDW)) dut (
        .clk100mhz(clk100mhz),
        .reset(reset),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .tx_rdy(tx_rdy),
        .tx_load(tx_load),
        .tx_data(tx_data),
        .gnt_id(gnt_id),
        .busy(busy)
    );

    logic [7:0] rq [NREQ][$];
    logic [7:0] mq [NREQ][$];
    exp_t       sb [$];
    int         m_ptr;
    int         n_cmp;
    int         n_bad;
    bit         hold;
    int         eng_cnt;

    initial clk100mhz = 1'b0;
    always #5 clk100mhz = ~clk100mhz;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NREQ; i++) begin
            req[i] = (rq[i].size() > 0);
            req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
        end
    endtask

    // Whole-batch model: all queued bytes are present before arbitration
    // starts, so the grant sequence follows from the queue contents alone.
    task automatic model_batch();
        int id;
        int n;
        bit any;
        for (int i = 0; i < NREQ; i++)
            mq[i] = rq[i];
        forever begin
            any = 0;
            for (int i = 0; i < NREQ; i++)
                if (mq[i].size() > 0)
                    any = 1;
            if (!any)
                break;
`ifdef TXARB_PRIORITY_EN
            if (mq[0].size() > 0) begin
                while (mq[0].size() > 0)
                    sb.push_back('{0, mq[0].pop_front()});
                continue;
            end
`endif
            id = -1;
            for (int k = 0; k < NREQ && id < 0; k++)
                if (mq[(m_ptr + k) % NREQ].size() > 0)
                    id = (m_ptr + k) % NREQ;
            n = 0;
            while (mq[id].size() > 0 && n < MB) begin
                sb.push_back('{id, mq[id].pop_front()});
                n++;
            end
            m_ptr = (id + 1) % NREQ;
`ifdef TXARB_PRIORITY_EN
            if (m_ptr == 0)
                m_ptr = 1;
`endif
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge clk100mhz);
            if (sb.size() == 0 && !busy && tx_rdy)
                done = 1;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL drain: %0d loads outstanding after timeout",
                     sb.size());
        end
    endtask

    // Requesters: pop the acked byte and present the next one.
    initial begin
        forever begin
            @(negedge clk100mhz);
            for (int i = 0; i < NREQ; i++)
                if (ack[i] && rq[i].size() > 0)
                    void'(rq[i].pop_front());
            refresh();
        end
    end

    // Engine: TXRDY low for a random frame time after each load.
    initial begin
        eng_cnt = 0;
        tx_rdy  = 1'b1;
        forever begin
            @(negedge clk100mhz);
            if (tx_load)
                eng_cnt = $urandom_range(2, 12);
            else if (eng_cnt > 0)
                eng_cnt--;
            tx_rdy = (eng_cnt == 0) && !hold;
        end
    end

    // Monitor: every load is checked against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk100mhz);
            if (tx_load) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_load: got id %0d data %0h, none expected",
                             gnt_id, tx_data);
                end else begin
                    e = sb.pop_front();
                    chk("gnt_id", 32'(gnt_id), e.id);
                    chk("tx_data", 32'(tx_data), 32'(e.d));
                    chk("ack", 32'(ack), 32'(1) << e.id);
                end
            end else if (ack != '0) begin
                chk("ack_without_load", 32'(ack), 0);
            end
        end
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        m_ptr   = 0;
        hold    = 0;
        reset   = 1'b0;
        req     = '0;
        req_data = '0;
        repeat (3) @(negedge clk100mhz);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tx_load", 32'(tx_load), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_gnt_id", 32'(gnt_id), 0);
        reset = 1'b1;
        @(negedge clk100mhz);

        // single byte, one-cycle latency
        rq[2].push_back(8'h2A);
        refresh();
        model_batch();
        @(negedge clk100mhz);
        chk("lat_tx_load", 32'(tx_load), 1);
        chk("lat_ack", 32'(ack), 32'h4);
        chk("lat_tx_data", 32'(tx_data), 32'h2A);
        chk("lat_gnt_id", 32'(gnt_id), 2);
        @(negedge clk100mhz);
        chk("pulse_tx_load", 32'(tx_load), 0);
        chk("pulse_ack", 32'(ack), 0);
        wait_drain();

        // engine busy when req[0] rises
        hold   = 1;
        tx_rdy = 1'b0;
        rq[0].push_back(8'hC3);
        refresh();
        model_batch();
        repeat (4) begin
            @(negedge clk100mhz);
            chk("wait_busy", 32'(busy), 0);
            chk("wait_tx_load", 32'(tx_load), 0);
        end
        hold   = 0;
        tx_rdy = 1'b1;
        @(negedge clk100mhz);
        chk("rdy_tx_load", 32'(tx_load), 1);
        wait_drain();

        // burst limit: requester 1 has more than MAX_BURST bytes
        hold   = 1;
        tx_rdy = 1'b0;
        for (int k = 0; k < 6; k++)
            rq[1].push_back(8'h40 + 8'(k));
        rq[3].push_back(8'h93);
        rq[3].push_back(8'h94);
        refresh();
        model_batch();
        @(negedge clk100mhz);
        hold   = 0;
        tx_rdy = 1'b1;
        wait_drain();

        // randomized batches
        for (int p = 0; p < 10; p++) begin
            int tot;
            hold   = 1;
            tx_rdy = 1'b0;
            tot    = 0;
            for (int i = 0; i < NREQ; i++) begin
                int n;
                n = $urandom_range(0, 7);
                for (int k = 0; k < n; k++)
                    rq[i].push_back(8'($urandom));
                tot += n;
            end
            if (tot == 0)
                rq[$urandom_range(0, NREQ - 1)].push_back(8'($urandom));
            refresh();
            model_batch();
            repeat (2) @(negedge clk100mhz);
            chk("batch_idle_busy", 32'(busy), 0);
            hold   = 0;
            tx_rdy = 1'b1;
            wait_drain();
        end

        // asynchronous reset while the engine is mid-frame
        rq[2].push_back(8'h77);
        refresh();
        model_batch();
        begin
            bit seen;
            seen = 0;
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge clk100mhz);
                if (tx_load)
                    seen = 1;
            end
            chk("mid_load_seen", 32'(seen), 1);
        end
        @(negedge clk100mhz);
        chk("mid_busy_before", 32'(busy), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_tx_load", 32'(tx_load), 0);
        chk("async_ack", 32'(ack), 0);
        chk("async_tx_data", 32'(tx_data), 0);
        chk("async_gnt_id", 32'(gnt_id), 0);
        m_ptr = 0;
        rq[3].push_back(8'hD3);
        rq[2].push_back(8'hD2);
        rq[1].push_back(8'hD1);
        refresh();
        model_batch();
        @(negedge clk100mhz);
        reset = 1'b1;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end
endmodule
